// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared state encoding and defaults for the cpu sequencer
//
// Purpose: state enum for the sequencer FSM, default reset PC, halt encoding,
//          PC step, and a word-alignment helper.
// Ports:   none (package).
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } seq_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INSN = 32'hFFFF_FFFF;
    localparam logic [31:0] DEFAULT_PC_STEP   = 32'd4;

    // Instruction fetches are word addressed; branch targets are forced onto
    // a word boundary so an unaligned target can never reach the memory bus.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_seq_pc.sv
// rtl/cpu_seq_pc.sv - program counter register with increment and branch redirect
//
// Purpose: holds pc; loads RESET_PC on restart, and on advance either steps
//          by PC_STEP (wrapping modulo 2^32) or takes the aligned branch target.
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   restart       in   load RESET_PC
//   advance       in   retire the current instruction (writeback cycle)
//   branch_taken  in   select branch_target instead of pc+PC_STEP on advance
//   branch_target in   redirect address (low two bits dropped)
//   pc            out  current program counter
module cpu_seq_pc
    import cpu_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        advance,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (restart) begin
            pc_d = RESET_PC;
        end else if (advance) begin
            pc_d = branch_taken ? align_word(branch_target) : pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute/writeback control FSM
//
// Purpose: fetches instructions over a req/ready handshake into the IR that
//          drives ID, gates the register-file write to the writeback cycle,
//          and advances or redirects the pc. Optional performance counters
//          are built when CPU_SEQ_PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   start                           leave IDLE/HALTED, fetch from RESET_PC
//   stall                           hold in EXECUTE
//   imem_req/imem_addr              fetch request and address (= pc)
//   imem_ready/imem_rdata           fetch data valid and instruction word
//   instruction                     IR contents to ID
//   id_write_enable/rf_write_enable decoded and gated register write enable
//   branch_taken/branch_target      redirect request, used in WRITEBACK
//   pc, busy, halted                status
//   retired_count, stall_count      (CPU_SEQ_PERF_CNT_EN only) counters
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_INSN = DEFAULT_HALT_INSN,
    parameter logic [31:0] PC_STEP   = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    input  logic        id_write_enable,
    output logic        rf_write_enable,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted
`ifdef CPU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] retired_count,
    output logic [31:0] stall_count
`endif
);

    seq_state_t  state_q;
    seq_state_t  state_d;
    logic [31:0] ir_q;
    logic        restart;
    logic        in_fetch;
    logic        in_execute;
    logic        in_writeback;

    assign in_fetch     = (state_q == ST_FETCH);
    assign in_execute   = (state_q == ST_EXECUTE);
    assign in_writeback = (state_q == ST_WRITEBACK);

    // start only has an effect from a resting state; while busy it is ignored.
    assign restart = start && ((state_q == ST_IDLE) || (state_q == ST_HALTED));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_FETCH;
            ST_FETCH:     if (imem_ready) state_d = ST_DECODE;
            ST_DECODE:    state_d = (ir_q == HALT_INSN) ? ST_HALTED : ST_EXECUTE;
            ST_EXECUTE:   if (!stall) state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALTED:    if (start) state_d = ST_FETCH;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IR captures only on the accepting fetch cycle; rdata elsewhere is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= 32'h0;
        end else if (restart) begin
            ir_q <= 32'h0;
        end else if (in_fetch && imem_ready) begin
            ir_q <= imem_rdata;
        end
    end

    cpu_seq_pc #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .restart       (restart),
        .advance       (in_writeback),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc)
    );

    // All status outputs decode the registered state, so start never reaches
    // an output combinationally and reset clears them immediately.
    assign imem_req        = in_fetch;
    assign imem_addr       = pc;
    assign instruction     = ir_q;
    assign rf_write_enable = in_writeback && id_write_enable;
    assign busy            = in_fetch || (state_q == ST_DECODE) || in_execute || in_writeback;
    assign halted          = (state_q == ST_HALTED);

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'h0;
            stall_q   <= 32'h0;
        end else if (restart) begin
            retired_q <= 32'h0;
            stall_q   <= 32'h0;
        end else begin
            if (in_writeback) begin
                retired_q <= retired_q + 32'd1;
            end
            if ((in_fetch && !imem_ready) || (in_execute && stall)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard testbench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        id_write_enable;
    logic        rf_write_enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
`ifdef CPU_SEQ_PERF_CNT_EN
    logic [31:0] retired_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] prog [256];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        int          cyc;
    } wb_t;

    wb_t         wb_q[$];
    logic [31:0] fetch_q[$];
    wb_t         mon_e;

    cpu_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .id_write_enable (id_write_enable),
        .rf_write_enable (rf_write_enable),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .pc              (pc),
        .busy            (busy),
        .halted          (halted)
`ifdef CPU_SEQ_PERF_CNT_EN
        ,
        .retired_count   (retired_count),
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory and a stand-in for ID/EXE: opcode B0 branches to a
    // sign-extended 24-bit target, opcode C0 does not write the register file.
    assign imem_rdata      = prog[imem_addr[9:2]];
    assign branch_taken    = (instruction[31:24] == 8'hB0);
    assign branch_target   = {{8{instruction[23]}}, instruction[23:0]};
    assign id_write_enable = (instruction[31:24] != 8'hC0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: compares every fetch address and every register write against
    // the expectations queued by the stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) begin
                if (fetch_q.size() > 0) begin
                    chk("fetch_addr", imem_addr, fetch_q[0]);
                    if (imem_ready) void'(fetch_q.pop_front());
                end else if (imem_ready) begin
                    chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
                end
            end
            if (rf_write_enable) begin
                if (wb_q.size() == 0) begin
                    chk1("unexpected_wb", rf_write_enable, 1'b0);
                end else begin
                    mon_e = wb_q.pop_front();
                    chk("wb_insn", instruction, mon_e.insn);
                    chk("wb_pc", pc, mon_e.pc);
                    chk("wb_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 100) begin
            tick();
            n++;
        end
        chk1(name, halted, 1'b1);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = HALT;
    endtask

    task automatic push_wb(input logic [31:0] insn, input logic [31:0] pcv, input int c);
        wb_t e;
        e.insn = insn;
        e.pc   = pcv;
        e.cyc  = c;
        wb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_n      = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        imem_ready = 1'b1;
        clear_prog();
        tick();
        tick();
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_rfwe", rf_write_enable, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", instruction, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single MOV: writeback in the 4th cycle after FETCH entry, then pc=4.
        prog[0] = 32'h0000_FFFF;
        s = cyc;
        fetch_q.push_back(32'h0);
        fetch_q.push_back(32'h4);
        push_wb(32'h0000_FFFF, 32'h0, s + 4);
        pulse_start();
        chk1("t1_busy_after_start", busy, 1'b1);
        wait_halted("t1_halted");
        chk("t1_pc", pc, 32'h4);
        chk("t1_ir", instruction, HALT);
        chk1("t1_busy", busy, 1'b0);

        // Three back-to-back instructions, plus a start while busy (ignored).
        clear_prog();
        prog[0] = 32'h0000_0001;
        prog[1] = 32'h2200_0001;
        prog[2] = 32'h6201_0000;
        s = cyc;
        for (int i = 0; i < 4; i++) fetch_q.push_back(32'(i * 4));
        push_wb(32'h0000_0001, 32'h0, s + 4);
        push_wb(32'h2200_0001, 32'h4, s + 8);
        push_wb(32'h6201_0000, 32'h8, s + 12);
        pulse_start();
        chk("t2_restart_pc", pc, 32'h0);
        chk("t2_restart_ir", instruction, 32'h0);
        chk1("t2_restart_busy", busy, 1'b1);
        chk1("t2_restart_halted", halted, 1'b0);
        tick_to(s + 6);
        pulse_start();
        wait_halted("t2_halted");
        chk("t2_pc", pc, 32'hC);
        for (int i = 0; i < 3; i++) tick();
        chk("t2_pc_frozen", pc, 32'hC);
        chk1("t2_still_halted", halted, 1'b1);

        // Memory wait 3 cycles, then execute stall 2 cycles: writeback at cycle 9.
        clear_prog();
        prog[0] = 32'h0000_0005;
        s = cyc;
        fetch_q.push_back(32'h0);
        fetch_q.push_back(32'h4);
        push_wb(32'h0000_0005, 32'h0, s + 9);
        imem_ready = 1'b0;
        pulse_start();
        tick_to(s + 4);
        imem_ready = 1'b1;
        tick_to(s + 6);
        stall = 1'b1;
        tick_to(s + 8);
        stall = 1'b0;
        wait_halted("t3_halted");
`ifdef CPU_SEQ_PERF_CNT_EN
        chk("t3_stall_count", stall_count, 32'd5);
        chk("t3_retired_count", retired_count, 32'd1);
`endif

        // Branch to an unaligned target: fetch continues at the aligned address.
        clear_prog();
        prog[0]  = 32'hB000_0107;
        prog[65] = 32'h0000_0007;
        s = cyc;
        fetch_q.push_back(32'h0);
        fetch_q.push_back(32'h104);
        fetch_q.push_back(32'h108);
        push_wb(32'hB000_0107, 32'h0, s + 4);
        push_wb(32'h0000_0007, 32'h104, s + 8);
        pulse_start();
        wait_halted("t4_halted");
        chk("t4_pc", pc, 32'h108);

        // pc wrap: branch to FFFF_FFFC, retire a non-writing instruction, pc=0.
        clear_prog();
        prog[0]   = 32'hB0FF_FFFC;
        prog[255] = 32'hC000_0000;
        s = cyc;
        fetch_q.push_back(32'h0);
        fetch_q.push_back(32'hFFFF_FFFC);
        fetch_q.push_back(32'h0);
        push_wb(32'hB0FF_FFFC, 32'h0, s + 4);
        pulse_start();
        tick_to(s + 2);
        prog[0] = HALT;
        wait_halted("t5_halted");
        chk("t5_pc_wrapped", pc, 32'h0);

        // Reset asserted mid-fetch drops the request without a clock edge.
        imem_ready = 1'b0;
        pulse_start();
        tick();
        chk1("t6_req_in_fetch", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t6_req_dropped", imem_req, 1'b0);
        chk1("t6_busy_dropped", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // start and stall together in IDLE: start wins.
        imem_ready = 1'b1;
        fetch_q.push_back(32'h0);
        start = 1'b1;
        stall = 1'b1;
        tick();
        start = 1'b0;
        stall = 1'b0;
        chk1("t7_start_wins", busy, 1'b1);
        wait_halted("t7_halted");

        tick();
        tick();
        chk("fetch_q_drained", fetch_q.size(), 32'd0);
        chk("wb_q_drained", wb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
